// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch control path.
// State encodings and timing constants used by the datapath.
package stopwatch_ctrl_pkg;

  localparam int STATE_W  = 3;
  localparam int CLK_HZ   = 50_000_000;
  localparam int TICK_HZ  = 100;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAUSE     = 3'd2,
    LAP_RUN   = 3'd3,
    LAP_PAUSE = 3'd4
  } sw_state_t;

  function automatic logic is_running(
    input sw_state_t s
  );
    return (s == RUN) || (s == LAP_RUN);
  endfunction

endpackage

// File: rtl/stopwatch_edge_detect.sv
// Rising-edge detector for one debounced button level.
// History resets to 1 so a button held through reset is not an event.
module stopwatch_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= lvl;
  end

  assign rise = lvl & ~prev;

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Run/pause/lap control FSM for the 4-digit BCD stopwatch.
// Turns button edges into counter, lap and display commands.
module stopwatch_ctrl_fsm
  import stopwatch_ctrl_pkg::*;
#(
  parameter int SATURATE = 1,
  parameter int STATE_W  = stopwatch_ctrl_pkg::STATE_W
) (
  input  logic               CLK_50M,
  input  logic               RST_N,
  input  logic               ss_lvl,
  input  logic               lap_lvl,
  input  logic               clr_lvl,
  input  logic               tick_100hz,
  input  logic               at_max,
  output logic               count_en,
  output logic               count_clr,
  output logic               lap_capture,
  output logic               show_lap,
  output logic               overflow,
  output logic [STATE_W-1:0] state_o
);

  logic ss_ev;
  logic lap_ev;
  logic clr_ev;

  stopwatch_edge_detect u_ss (
    .clk   (CLK_50M),
    .rst_n (RST_N),
    .lvl   (ss_lvl),
    .rise  (ss_ev)
  );

  stopwatch_edge_detect u_lap (
    .clk   (CLK_50M),
    .rst_n (RST_N),
    .lvl   (lap_lvl),
    .rise  (lap_ev)
  );

  stopwatch_edge_detect u_clr (
    .clk   (CLK_50M),
    .rst_n (RST_N),
    .lvl   (clr_lvl),
    .rise  (clr_ev)
  );

  sw_state_t state;
  sw_state_t state_nxt;
  logic      cap_nxt;
  logic      sat;
  logic      sat_hit;
  logic      ss_ok;

  assign sat = (SATURATE != 0);

  assign sat_hit = sat & tick_100hz & at_max
                 & is_running(state);

  // Once saturated, start/stop cannot resume until cleared.
  assign ss_ok = ss_ev & ~(at_max & overflow);

  always_comb begin
    state_nxt = state;
    cap_nxt   = 1'b0;
    if (clr_ev) begin
      state_nxt = IDLE;
    end else if (sat_hit) begin
      state_nxt = (state == RUN) ? PAUSE : LAP_PAUSE;
    end else begin
      case (state)
        IDLE: begin
          if (ss_ok) state_nxt = RUN;
        end
        RUN: begin
          if (ss_ok) begin
            state_nxt = PAUSE;
          end else if (lap_ev) begin
            state_nxt = LAP_RUN;
            cap_nxt   = 1'b1;
          end
        end
        PAUSE: begin
          if (ss_ok) begin
            state_nxt = RUN;
          end else if (lap_ev) begin
            state_nxt = LAP_PAUSE;
            cap_nxt   = 1'b1;
          end
        end
        LAP_RUN: begin
          if (ss_ok)       state_nxt = LAP_PAUSE;
          else if (lap_ev) state_nxt = RUN;
        end
        LAP_PAUSE: begin
          if (ss_ok)       state_nxt = LAP_RUN;
          else if (lap_ev) state_nxt = PAUSE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      count_clr   <= 1'b0;
      lap_capture <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      count_clr   <= clr_ev;
      lap_capture <= cap_nxt;
      if (clr_ev)       overflow <= 1'b0;
      else if (sat_hit) overflow <= 1'b1;
    end
  end

  assign count_en = tick_100hz & is_running(state)
                  & ~(sat & at_max) & ~clr_ev;

  assign show_lap = (state == LAP_RUN)
                 || (state == LAP_PAUSE);

  assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Directed-vector bench for the stopwatch control FSM.
// Covers saturating and wrapping builds side by side.
module tb_stopwatch_ctrl_fsm;

  logic       CLK_50M = 1'b0;
  logic       RST_N   = 1'b0;
  logic       ss_lvl  = 1'b1;
  logic       lap_lvl = 1'b0;
  logic       clr_lvl = 1'b0;
  logic       tick    = 1'b0;
  logic       at_max  = 1'b0;

  logic       en_s, cc_s, cap_s, sh_s, ov_s;
  logic [2:0] st_s;
  logic       en_w, cc_w, cap_w, sh_w, ov_w;
  logic [2:0] st_w;

  always #10 CLK_50M = ~CLK_50M;

  stopwatch_ctrl_fsm #(.SATURATE(1), .STATE_W(3)) dut (
    .CLK_50M     (CLK_50M),
    .RST_N       (RST_N),
    .ss_lvl      (ss_lvl),
    .lap_lvl     (lap_lvl),
    .clr_lvl     (clr_lvl),
    .tick_100hz  (tick),
    .at_max      (at_max),
    .count_en    (en_s),
    .count_clr   (cc_s),
    .lap_capture (cap_s),
    .show_lap    (sh_s),
    .overflow    (ov_s),
    .state_o     (st_s)
  );

  stopwatch_ctrl_fsm #(.SATURATE(0), .STATE_W(3)) dut_w (
    .CLK_50M     (CLK_50M),
    .RST_N       (RST_N),
    .ss_lvl      (ss_lvl),
    .lap_lvl     (lap_lvl),
    .clr_lvl     (clr_lvl),
    .tick_100hz  (tick),
    .at_max      (at_max),
    .count_en    (en_w),
    .count_clr   (cc_w),
    .lap_capture (cap_w),
    .show_lap    (sh_w),
    .overflow    (ov_w),
    .state_o     (st_w)
  );

  typedef struct {
    logic       ss, lap, clr, tk, am;
    logic       en;
    logic [2:0] st;
    logic       cc, cap, sh, ov;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(
    input logic ss, lap, clr, tk, am,
    input logic en, input logic [2:0] st,
    input logic cc, cap, sh, ov
  );
    vec_t v;
    v = '{ss, lap, clr, tk, am,
          en, st, cc, cap, sh, ov};
    vecs.push_back(v);
  endtask

  task automatic chk(
    input string nm,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  initial begin
    logic       got_en;
    logic [7:0] got, want;

    // ss held high through reset release
    repeat (2) @(posedge CLK_50M);
    #1;
    chk("reset_state",
        {2'b0, en_s, cc_s, cap_s, sh_s, ov_s, st_s == 3'd0},
        8'h01);
    @(negedge CLK_50M);
    RST_N = 1'b1;
    @(posedge CLK_50M);
    #1;

    //   ss lap clr tk am | en st cc cap sh ov
    repeat (10) add(1,0,0,1,0, 0,3'd0, 0,0,0,0);
    add(0,0,0,0,0, 0,3'd0, 0,0,0,0);
    add(1,0,0,0,0, 0,3'd1, 0,0,0,0);
    repeat (5) begin
      add(0,0,0,1,0, 1,3'd1, 0,0,0,0);
      add(0,0,0,0,0, 0,3'd1, 0,0,0,0);
    end
    add(1,0,0,0,0, 0,3'd2, 0,0,0,0);
    add(0,0,0,1,0, 0,3'd2, 0,0,0,0);
    add(0,0,0,1,0, 0,3'd2, 0,0,0,0);
    add(1,0,0,0,0, 0,3'd1, 0,0,0,0);
    add(0,0,0,0,0, 0,3'd1, 0,0,0,0);
    add(0,1,0,0,0, 0,3'd3, 0,1,1,0);
    add(0,0,0,0,0, 0,3'd3, 0,0,1,0);
    add(0,0,0,1,0, 1,3'd3, 0,0,1,0);
    add(0,1,0,0,0, 0,3'd1, 0,0,0,0);
    add(0,0,0,0,0, 0,3'd1, 0,0,0,0);
    add(1,0,0,0,0, 0,3'd2, 0,0,0,0);
    add(0,0,0,0,0, 0,3'd2, 0,0,0,0);
    add(0,1,0,0,0, 0,3'd4, 0,1,1,0);
    add(0,0,0,1,0, 0,3'd4, 0,0,1,0);
    add(1,1,1,0,0, 0,3'd0, 1,0,0,0);
    add(0,0,0,0,0, 0,3'd0, 0,0,0,0);
    add(1,0,0,0,0, 0,3'd1, 0,0,0,0);
    add(0,0,0,1,1, 0,3'd2, 0,0,0,1);
    add(0,0,0,0,1, 0,3'd2, 0,0,0,1);
    add(1,0,0,0,1, 0,3'd2, 0,0,0,1);
    add(0,0,0,0,1, 0,3'd2, 0,0,0,1);
    add(0,0,1,0,0, 0,3'd0, 1,0,0,0);
    add(0,0,0,0,0, 0,3'd0, 0,0,0,0);

    foreach (vecs[i]) begin
      ss_lvl  = vecs[i].ss;
      lap_lvl = vecs[i].lap;
      clr_lvl = vecs[i].clr;
      tick    = vecs[i].tk;
      at_max  = vecs[i].am;
      @(negedge CLK_50M);
      got_en = en_s;
      @(posedge CLK_50M);
      #1;
      got  = {got_en, st_s, cc_s, cap_s, sh_s, ov_s};
      want = {vecs[i].en, vecs[i].st,
              vecs[i].cc, vecs[i].cap,
              vecs[i].sh, vecs[i].ov};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL vec%0d: got %b want %b",
                 i, got, want);
      end
    end

    // wrap build vs saturating build at 99.99
    ss_lvl = 1'b1;
    @(posedge CLK_50M);
    #1;
    chk("run_sat", {5'b0, st_s}, 8'd1);
    chk("run_wrap", {5'b0, st_w}, 8'd1);
    ss_lvl = 1'b0;
    tick   = 1'b1;
    at_max = 1'b1;
    @(negedge CLK_50M);
    chk("en_sat_max", {7'b0, en_s}, 8'd0);
    chk("en_wrap_max", {7'b0, en_w}, 8'd1);
    @(posedge CLK_50M);
    #1;
    chk("st_wrap", {5'b0, st_w}, 8'd1);
    chk("ov_wrap", {7'b0, ov_w}, 8'd0);
    chk("st_sat", {5'b0, st_s}, 8'd2);
    chk("ov_sat", {7'b0, ov_s}, 8'd1);

    // asynchronous reset mid-run, between edges
    at_max = 1'b0;
    #4;
    chk("en_wrap_pre", {7'b0, en_w}, 8'd1);
    RST_N = 1'b0;
    #1;
    chk("arst_wrap",
        {en_w, cc_w, cap_w, sh_w, ov_w, st_w},
        8'd0);
    chk("arst_sat",
        {en_s, cc_s, cap_s, sh_s, ov_s, st_s},
        8'd0);
    tick = 1'b0;
    @(negedge CLK_50M);
    RST_N = 1'b1;
    @(posedge CLK_50M);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
